// File: rtl/pedal_pkg.sv
// Shared types and constants for the pedal signal chain.
// Samples are 24-bit signed; gate gain is 9-bit unsigned with 256 as unity.
package pedal_pkg;

  typedef logic signed [23:0] sample_t;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } gate_state_e;

  localparam int          GAIN_W     = 9;
  localparam logic [8:0]  GAIN_UNITY = 9'd256;

endpackage

// File: rtl/noise_gate_if.sv
// Sample-rate bus between the upstream source, the noise gate and the distortion stage.
// The gate itself attaches through the slave modport.
interface noise_gate_if;
  import pedal_pkg::*;

  logic [31:0] x;
  logic [3:0]  en;
  logic [31:0] y;
  logic        gate_open;
  gate_state_e gate_state;

  modport master (
    output x, en,
    input  y, gate_open, gate_state
  );

  modport slave (
    input  x, en,
    output y, gate_open, gate_state
  );

endinterface

// File: rtl/envelope_follower.sv
// Peak envelope: instant attack on |xs|, exponential decay env - (env >> ENV_SHIFT).
// One register stage; env reflects samples up to the previous clock.
module envelope_follower
  import pedal_pkg::*;
#(
  parameter int ENV_SHIFT = 6
) (
  input  logic        clk_48,
  input  logic        rst,
  input  sample_t     xs,
  output logic [23:0] env
);

  logic [23:0] w_mag;
  logic [23:0] r_env;

  // Full-scale negative wraps to 0x800000, which read unsigned is the correct magnitude.
  assign w_mag = xs[23] ? 24'(-xs) : 24'(xs);

  always_ff @(posedge clk_48) begin
    if (rst) begin
      r_env <= '0;
    end else if (w_mag > r_env) begin
      r_env <= w_mag;
    end else begin
      r_env <= r_env - (r_env >> ENV_SHIFT);
    end
  end

  assign env = r_env;

endmodule

// File: rtl/noise_gate.sv
// Noise gate ahead of the distortion stage: envelope-driven FSM ramps a 9-bit gain.
// y is registered, 1-cycle latency; en[1]=0 passes x straight through with the gate forced open.
module noise_gate
  import pedal_pkg::*;
#(
  parameter int unsigned THRESH_OPEN  = 2000,
  parameter int unsigned THRESH_CLOSE = 1000,
  parameter int unsigned HOLD_SAMPLES = 2400,
  parameter int unsigned ATTACK_STEP  = 32,
  parameter int unsigned RELEASE_STEP = 1,
  parameter int          ENV_SHIFT    = 6
) (
  input  logic         clk_48,
  input  logic         rst,
  noise_gate_if.slave  bus
);

  localparam int          HOLD_W   = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [23:0] TH_OPEN  = 24'(THRESH_OPEN);
  localparam logic [23:0] TH_CLOSE = 24'(THRESH_CLOSE);

  gate_state_e        r_state;
  gate_state_e        w_state_nxt;
  logic [GAIN_W-1:0]  r_gain;
  logic [GAIN_W-1:0]  w_gain_nxt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [31:0]        r_y;

  sample_t            w_xs;
  logic [23:0]        w_env;
  logic               w_open_hit;
  logic               w_close_hit;
  logic [GAIN_W:0]    w_gain_sum;
  logic [GAIN_W-1:0]  w_gain_att;
  logic [GAIN_W-1:0]  w_gain_rel;
  logic signed [33:0] w_prod;
  logic [31:0]        w_scaled;
  logic               w_unused;

  assign w_xs     = bus.x[23:0];
  assign w_unused = ^{bus.en[3:2], bus.en[0]};

  envelope_follower #(
    .ENV_SHIFT (ENV_SHIFT)
  ) u_env (
    .clk_48 (clk_48),
    .rst    (rst),
    .xs     (w_xs),
    .env    (w_env)
  );

  assign w_open_hit  = (w_env >= TH_OPEN);
  assign w_close_hit = (w_env < TH_CLOSE);

  assign w_gain_sum = {1'b0, r_gain} + (GAIN_W+1)'(ATTACK_STEP);
  assign w_gain_att = (w_gain_sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : w_gain_sum[GAIN_W-1:0];
  assign w_gain_rel = (r_gain > GAIN_W'(RELEASE_STEP)) ? (r_gain - GAIN_W'(RELEASE_STEP)) : '0;

  always_ff @(posedge clk_48) begin
    if (rst) begin
      r_state    <= CLOSED;
      r_gain     <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gain     <= w_gain_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // Re-open is tested first in HOLD and RELEASE so it wins over countdown/ramp completion.
  always_comb begin
    w_state_nxt = r_state;
    w_gain_nxt  = r_gain;
    w_hold_nxt  = r_hold_cnt;
    if (!bus.en[1]) begin
      w_state_nxt = OPEN;
      w_gain_nxt  = GAIN_UNITY;
    end else begin
      case (r_state)
        CLOSED: begin
          w_gain_nxt = '0;
          if (w_open_hit) w_state_nxt = ATTACK;
        end
        ATTACK: begin
          w_gain_nxt = w_gain_att;
          if (w_gain_att == GAIN_UNITY) w_state_nxt = OPEN;
        end
        OPEN: begin
          w_gain_nxt = GAIN_UNITY;
          if (w_close_hit) begin
            w_state_nxt = HOLD;
            w_hold_nxt  = HOLD_W'(HOLD_SAMPLES - 1);
          end
        end
        HOLD: begin
          w_gain_nxt = GAIN_UNITY;
          if (w_open_hit)            w_state_nxt = OPEN;
          else if (r_hold_cnt == '0) w_state_nxt = RELEASE;
          else                       w_hold_nxt  = r_hold_cnt - 1'b1;
        end
        RELEASE: begin
          w_gain_nxt = w_gain_rel;
          if (w_open_hit)              w_state_nxt = ATTACK;
          else if (w_gain_rel == '0)   w_state_nxt = CLOSED;
        end
        default: begin
          w_state_nxt = CLOSED;
          w_gain_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.gate_open  = (r_state != CLOSED);
    bus.gate_state = r_state;
  end

  // Arithmetic shift floors toward -inf; with gain <= 256 the result already fits 24 bits
  // sign-extended, so the low 32 bits are the finished output word.
  assign w_prod   = 34'(w_xs) * 34'($signed({1'b0, r_gain}));
  assign w_scaled = 32'(w_prod >>> 8);

  always_ff @(posedge clk_48) begin
    if (rst) begin
      r_y <= '0;
    end else if (!bus.en[1]) begin
      r_y <= bus.x;
    end else begin
      r_y <= w_scaled;
    end
  end

  assign bus.y = r_y;

endmodule

// File: tb/tb_noise_gate.sv
// Directed and randomized checks of noise_gate against an arithmetic reference model.
// Every cycle compares y, gate_open and gate_state; directed steps add boundary checks.
module tb_noise_gate;

  localparam int TH_OPEN  = 2000;
  localparam int TH_CLOSE = 1000;
  localparam int HOLD_N   = 2400;
  localparam int ATT_STEP = 32;
  localparam int REL_STEP = 1;

  localparam int S_CLOSED  = 0;
  localparam int S_ATTACK  = 1;
  localparam int S_OPEN    = 2;
  localparam int S_HOLD    = 3;
  localparam int S_RELEASE = 4;

  logic clk_48;
  logic rst;
  noise_gate_if bus ();

  noise_gate u_dut (
    .clk_48 (clk_48),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk_48 = 1'b0;
  always #5 clk_48 = ~clk_48;

  int n_vec = 0;
  int n_err = 0;

  // Reference state kept as plain integers.
  int          m_env, m_gain, m_hold, m_st;
  logic [31:0] m_y;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [31:0] xv, input logic [3:0] ev, input logic rv);
    int xs, a;
    xs = $signed(xv[23:0]);
    a  = (xs < 0) ? -xs : xs;
    if (rv) begin
      m_env = 0; m_gain = 0; m_hold = 0; m_st = S_CLOSED; m_y = '0;
      return;
    end
    if (!ev[1]) begin
      m_y = xv; m_st = S_OPEN; m_gain = 256;
    end else begin
      m_y = 32'((longint'(xs) * m_gain) >>> 8);
      case (m_st)
        S_CLOSED: if (m_env >= TH_OPEN) m_st = S_ATTACK;
        S_ATTACK: begin
          m_gain = (m_gain + ATT_STEP > 256) ? 256 : m_gain + ATT_STEP;
          if (m_gain == 256) m_st = S_OPEN;
        end
        S_OPEN: if (m_env < TH_CLOSE) begin m_st = S_HOLD; m_hold = HOLD_N - 1; end
        S_HOLD: begin
          if (m_env >= TH_OPEN)  m_st = S_OPEN;
          else if (m_hold == 0)  m_st = S_RELEASE;
          else                   m_hold--;
        end
        S_RELEASE: begin
          m_gain = (m_gain > REL_STEP) ? m_gain - REL_STEP : 0;
          if (m_env >= TH_OPEN)  m_st = S_ATTACK;
          else if (m_gain == 0)  m_st = S_CLOSED;
        end
        default: m_st = S_CLOSED;
      endcase
    end
    if (a > m_env) m_env = a;
    else           m_env = m_env - (m_env >> 6);
  endtask

  task automatic step(input logic [31:0] xv, input logic [3:0] ev, input logic rv);
    @(negedge clk_48);
    bus.x  = xv;
    bus.en = ev;
    rst    = rv;
    @(posedge clk_48);
    model_step(xv, ev, rv);
    #1;
    chk("y", bus.y, m_y);
    chk("gate_open", 32'(bus.gate_open), 32'(m_st != S_CLOSED));
    chk("gate_state", 32'(bus.gate_state), 32'(m_st));
  endtask

  initial begin
    int n;
    logic [31:0] xv;
    logic [3:0]  ev;
    m_env = 0; m_gain = 0; m_hold = 0; m_st = S_CLOSED; m_y = '0;
    rst    = 1'b1;
    bus.x  = 32'd5000;
    bus.en = 4'b0010;

    // Reset with a loud input applied
    step(32'd5000, 4'b0010, 1'b1);
    step(32'd5000, 4'b0010, 1'b1);
    chk("rst_y", bus.y, 32'd0);
    chk("rst_state", 32'(bus.gate_state), S_CLOSED);

    // Sub-threshold noise stays muted
    for (int i = 0; i < 1000; i++)
      step((i % 2) ? 32'(-500) : 32'd500, 4'b0010, 1'b0);
    chk("noise_y", bus.y, 32'd0);
    chk("noise_state", 32'(bus.gate_state), S_CLOSED);

    // Attack ramp to unity, then a negative sample at unity
    for (int i = 0; i < 12; i++) step(32'd5000, 4'b0010, 1'b0);
    chk("attack_open", 32'(bus.gate_state), S_OPEN);
    step(32'hFFFF_EC78, 4'b0010, 1'b0);
    chk("neg_unity", bus.y, 32'hFFFF_EC78);

    // Close: decay into HOLD, count HOLD and RELEASE lengths
    n = 0;
    while (bus.gate_state != S_HOLD && n < 300) begin step(32'd0, 4'b0010, 1'b0); n++; end
    chk("reach_hold", 32'(bus.gate_state), S_HOLD);
    n = 0;
    while (bus.gate_state == S_HOLD && n < 3000) begin step(32'd0, 4'b0010, 1'b0); n++; end
    chk("hold_len", 32'(n), HOLD_N);
    n = 0;
    while (bus.gate_state == S_RELEASE && n < 400) begin
      step(32'd1500, 4'b0010, 1'b0);
      n++;
      if (n == 129) chk("mid_release", bus.y, 32'd750);
    end
    chk("release_len", 32'(n), 256);
    chk("closed_open", 32'(bus.gate_open), 32'd0);

    // Retrigger during HOLD at hold_cnt=100
    n = 0;
    while (bus.gate_state != S_OPEN && n < 20) begin step(32'd5000, 4'b0010, 1'b0); n++; end
    n = 0;
    while (bus.gate_state != S_HOLD && n < 300) begin step(32'd0, 4'b0010, 1'b0); n++; end
    chk("reach_hold2", 32'(bus.gate_state), S_HOLD);
    for (int i = 0; i < HOLD_N - 1 - 100; i++) step(32'd0, 4'b0010, 1'b0);
    step(32'd3000, 4'b0010, 1'b0);
    step(32'd0, 4'b0010, 1'b0);
    chk("retrig_open", 32'(bus.gate_state), S_OPEN);
    step(32'd1000, 4'b0010, 1'b0);
    chk("retrig_unity", bus.y, 32'd1000);

    // Retrigger during RELEASE resumes the attack ramp
    n = 0;
    while (bus.gate_state != S_RELEASE && n < 3000) begin step(32'd0, 4'b0010, 1'b0); n++; end
    chk("reach_release", 32'(bus.gate_state), S_RELEASE);
    for (int i = 0; i < 60; i++) step(32'd0, 4'b0010, 1'b0);
    step(32'd3000, 4'b0010, 1'b0);
    step(32'd3000, 4'b0010, 1'b0);
    chk("rel_reattack", 32'(bus.gate_state), S_ATTACK);
    for (int i = 0; i < 6; i++) step(32'd3000, 4'b0010, 1'b0);

    // Bypass passes all 32 bits, then full-scale negative at unity
    step(32'hAB80_0000, 4'b0000, 1'b0);
    chk("bypass_y", bus.y, 32'hAB80_0000);
    chk("bypass_state", 32'(bus.gate_state), S_OPEN);
    step(32'h0080_0000, 4'b0010, 1'b0);
    chk("fullscale_neg", bus.y, 32'hFF80_0000);

    // Reset in the middle of an attack ramp
    step(32'd0, 4'b0010, 1'b1);
    for (int i = 0; i < 4; i++) step(32'd5000, 4'b0010, 1'b0);
    chk("mid_ramp_state", 32'(bus.gate_state), S_ATTACK);
    step(32'd5000, 4'b0010, 1'b1);
    chk("mid_ramp_rst", 32'(bus.gate_state), S_CLOSED);

    // Randomized mix of noise, signal, full-range words, bypass and reset
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       xv = 32'($signed($urandom_range(0, 1800)) - 900);
        1:       xv = 32'($signed($urandom_range(0, 10000)) - 5000);
        2:       xv = $urandom;
        default: xv = 32'd0;
      endcase
      ev    = 4'($urandom);
      ev[1] = ($urandom_range(0, 15) != 0);
      step(xv, ev, ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
